// File: rtl/ex_div_ctrl_pkg.sv
// rtl/ex_div_ctrl_pkg.sv - shared types and constants for the iterative divide sequencer
package ex_div_ctrl_pkg;

  localparam int DIV_XLEN = 32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // ALU op codes and result class consumed by the ex stage decode/mux
  localparam logic [7:0] EXE_DIV  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU = 8'b0001_1011;
  localparam logic [7:0] EXE_REM  = 8'b0001_1100;
  localparam logic [7:0] EXE_REMU = 8'b0001_1101;

  localparam logic [2:0] EXE_RES_DIV = 3'b110;

endpackage

// File: rtl/ex_div_ctrl_if.sv
// rtl/ex_div_ctrl_if.sv - request/result bundle between the ex stage and the divider
interface ex_div_ctrl_if #(
  parameter int XLEN = ex_div_ctrl_pkg::DIV_XLEN
);
  logic            start_i;
  logic            annul_i;
  logic            signed_i;
  logic            rem_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [XLEN-1:0] result_o;
  logic            ready_o;
  logic            stall_o;

  modport master (
    output start_i, annul_i, signed_i, rem_i, dividend_i, divisor_i,
    input  result_o, ready_o, stall_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, rem_i, dividend_i, divisor_i,
    output result_o, ready_o, stall_o
  );
endinterface

// File: rtl/ex_div_ctrl_div_step.sv
// rtl/ex_div_ctrl_div_step.sv - one combinational restoring shift/subtract step
module ex_div_ctrl_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quot_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // The quotient register still holds unconsumed dividend bits in its upper end
  always_comb begin
    shifted = {rem_i, quot_i[XLEN-1]};
    diff    = shifted - {1'b0, divisor_i};
    if (!diff[XLEN]) begin
      rem_o  = diff[XLEN-1:0];
      quot_o = {quot_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o  = shifted[XLEN-1:0];
      quot_o = {quot_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div_ctrl.sv
// rtl/ex_div_ctrl.sv - RV32M DIV/DIVU/REM/REMU sequencer: FSM, step counter, sign fix-up
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input logic         clk,
  input logic         rst,
  ex_div_ctrl_if.slave div
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  rem_q, quot_q, dsor_q;
  logic [XLEN-1:0]  step_rem, step_quot;
  logic             neg_quot_q, neg_rem_q, rem_sel_q;
  logic             load, load_zero, do_step;
  logic             dvd_neg, dvs_neg;
  logic [XLEN-1:0]  dvd_mag, dvs_mag, res_val;

  assign dvd_neg = div.signed_i & div.dividend_i[XLEN-1];
  assign dvs_neg = div.signed_i & div.divisor_i[XLEN-1];
  assign dvd_mag = dvd_neg ? (~div.dividend_i + 1'b1) : div.dividend_i;
  assign dvs_mag = dvs_neg ? (~div.divisor_i + 1'b1) : div.divisor_i;

  ex_div_ctrl_div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (dsor_q),
    .rem_o     (step_rem),
    .quot_o    (step_quot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DIV_FREE;
    else     state_q <= state_d;
  end

  // annul_i overrides every transition, including the final step
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_zero = 1'b0;
    do_step   = 1'b0;
    if (div.annul_i) begin
      state_d = DIV_FREE;
    end else begin
      case (state_q)
        DIV_FREE: begin
          if (div.start_i == DIV_START) begin
            if (div.divisor_i == '0) begin
              load_zero = 1'b1;
              state_d   = DIV_BYZERO;
            end else begin
              load    = 1'b1;
              state_d = DIV_ON;
            end
          end
        end
        DIV_BYZERO: state_d = DIV_END;
        DIV_ON: begin
          do_step = 1'b1;
          if (cnt_q == LAST_STEP) state_d = DIV_END;
        end
        DIV_END: if (div.start_i == DIV_STOP) state_d = DIV_FREE;
        default: state_d = DIV_FREE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dsor_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      rem_sel_q  <= 1'b0;
    end else if (load) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= dvd_mag;
      dsor_q     <= dvs_mag;
      neg_quot_q <= dvd_neg ^ dvs_neg;
      neg_rem_q  <= dvd_neg;
      rem_sel_q  <= div.rem_i;
    end else if (load_zero) begin
      // RISC-V x/0: quotient all ones, remainder is the raw dividend, no sign fix-up
      cnt_q      <= '0;
      rem_q      <= div.dividend_i;
      quot_q     <= '1;
      dsor_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      rem_sel_q  <= div.rem_i;
    end else if (do_step) begin
      cnt_q  <= cnt_q + 1'b1;
      rem_q  <= step_rem;
      quot_q <= step_quot;
    end
  end

  always_comb begin
    if (rem_sel_q) res_val = neg_rem_q  ? (~rem_q + 1'b1)  : rem_q;
    else           res_val = neg_quot_q ? (~quot_q + 1'b1) : quot_q;
  end

  always_comb begin
    div.ready_o  = DIV_RESULT_NOT_READY;
    div.stall_o  = 1'b0;
    div.result_o = '0;
    if (!rst && !div.annul_i) begin
      div.stall_o = ((state_q == DIV_FREE) && div.start_i) ||
                    (state_q == DIV_ON) || (state_q == DIV_BYZERO);
      if (state_q == DIV_END) begin
        div.ready_o  = DIV_RESULT_READY;
        div.result_o = res_val;
      end
    end
  end

endmodule
